complex_vxc_chunk_sequencer: RTL
================================

// Module: complex_vxc_chunk_sequencer
// PURPOSE
// Drives the NI-lane complex vXc-add datapath (y op x*conj(c)) over a NOE-element vector.
// - Accepts x/y chunks from upstream and zero-pads the tail chunk.
// - Issues one chunk at a time to the datapath and waits its fixed pipeline latency.
// - Captures the result chunk with a lane-valid mask and hands it downstream.
// - Pulses done after the final chunk is accepted downstream.
// PARAMETERS
// NOE            19  elements per vector
// NI             8   lanes per chunk
// element_width  64  complex element: [63:32] real fp32, [31:0] imag fp32
// LATENCY        8   clocks from datapath input register to valid dp_result (>=1)
// PORTS
// clk             in   1                clock, rising edge
// reset           in   1                asynchronous, active-low
// start           in   1                begin a vector pass; sampled in IDLE only
// op_in           in   1                0 = add, 1 = subtract; latched at start
// constant_in     in   element_width    complex constant c; latched at start
// in_valid        in   1                upstream chunk valid
// in_ready        out  1                sequencer accepts a chunk
// in_x            in   element_width*NI x chunk, lane j at [w*(NI-j)-1 -: w]
// in_y            in   element_width*NI y chunk, same lane order
// dp_first_row    out  element_width*NI registered x to datapath
// dp_second_row   out  element_width*NI registered y to datapath
// dp_constant     out  element_width    latched c
// dp_op           out  1                latched op
// dp_result       in   element_width*NI datapath result
// out_valid       out  1                result chunk valid
// out_ready       in   1                downstream accepts
// out_data        out  element_width*NI result chunk, padded lanes forced to 0
// out_mask        out  NI               bit j = lane j holds a real element
// busy            out  1                high in every state except IDLE
// done            out  1                one-cycle pulse after the last chunk is accepted
// BEHAVIOUR
// - CHUNKS = ceil(NOE/NI); LAST_LANES = NOE-(CHUNKS-1)*NI (1..NI). No extra chunk when NOE%NI==0.
// - Reset (async, reset==0): state IDLE; chunk_idx=0; lat_cnt=0; all outputs 0, incl. dp_* and out_mask.
// - IDLE: start=1 latches op_in and constant_in, chunk_idx=0 -> LOAD. start outside IDLE is ignored.
// - LOAD: in_ready=1. On in_valid&in_ready (edge t0): register x/y into dp_first_row/dp_second_row.
//   When chunk_idx==CHUNKS-1, lanes >= LAST_LANES are loaded as 0. lat_cnt=0 -> WAIT.
// - WAIT: in_ready=0; dp_* held stable; lat_cnt increments each clock.
//   On the LATENCY-th edge after t0: out_data <= dp_result with padded lanes zeroed; out_mask set;
//   out_valid=1 -> HOLD.
// - HOLD: out_data/out_mask stable while out_valid=1 and out_ready=0.
//   On out_ready: out_valid=0. If last chunk -> DONE, else chunk_idx+1 -> LOAD.
// - DONE: done=1 for exactly one cycle; busy=1 -> IDLE. out_mask is cleared.
// - out_mask: all ones for full chunks; low LAST_LANES bits set for the last chunk (lane 0 = bit 0).
// - At most one chunk is outstanding; in_ready is never high while out_valid=1.
// - Reset mid-pass aborts immediately: no done pulse, and the partial pass is lost.
// - in_valid while in_ready=0 is ignored; upstream holds the data.
// - No arithmetic is performed here; element values pass bit-exact.
// STRUCTURE
// - Shared package/header: element_width, complex field split (REAL_MSB=63, IMAG_MSB=31),
//   state encoding (IDLE, LOAD, WAIT, HOLD, DONE), and the CHUNKS/LAST_LANES functions.
// - One sub-module: complex_chunk_pad_mask (combinational) — valid lane count -> zeroed chunk + mask.
//   It is reused on the input and output sides.
// - Sequencer FSM, chunk counter and latency counter live in this module.
// TESTING
// 1. NOE=19, NI=8, LATENCY=8: 3 chunks, in_valid always 1, out_ready always 1
//    -> out_mask 8'hFF, 8'hFF, 8'h07; done pulses once; lanes 3..7 of chunk 2 are 0.
// 2. NOE=16: exactly 2 chunks, both masks 8'hFF; no third chunk is requested.
// 3. Hold out_ready low 5 cycles on chunk 0 -> out_data stable; in_ready stays 0; next load only after accept.
// 4. Model dp_result = dp_first_row delayed 8 clocks; send x lanes = 64'h3F800000_00000000
//    -> out_data equals that value exactly LATENCY edges after the load.
// 5. Assert reset low during WAIT of chunk 1 -> all outputs 0 at once; no done; a fresh start runs cleanly.
// 6. Pulse start while busy=1 -> ignored; latched constant/op unchanged; pass completes normally.

Source files
------------

// File: rtl/complex_vxc_chunk_sequencer_pkg.sv
// Shared definitions for the complex vXc-add chunk sequencer: element layout,
// sequencer state encoding and chunk-count helpers.
package complex_vxc_chunk_sequencer_pkg;

  localparam int ELEMENT_WIDTH = 64;
  localparam int REAL_MSB      = 63;
  localparam int IMAG_MSB      = 31;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_DONE = 3'd4
  } seq_state_e;

  // Number of NI-lane chunks needed to cover NOE elements (no empty tail chunk).
  function automatic int chunks_f(input int noe, input int ni);
    return (noe + ni - 1) / ni;
  endfunction

  // Real elements in the final chunk, always in 1..NI.
  function automatic int last_lanes_f(input int noe, input int ni);
    return noe - (chunks_f(noe, ni) - 1) * ni;
  endfunction

endpackage

// File: rtl/complex_chunk_pad_mask.sv
// Keeps the first valid_lanes lanes of a chunk (lane 0 in the top element slot),
// zeroes the rest and reports which lanes hold real elements.
module complex_chunk_pad_mask
  import complex_vxc_chunk_sequencer_pkg::*;
#(
  parameter int NI = 8,
  parameter int LW = $clog2(NI + 1)
) (
  input  logic [ELEMENT_WIDTH*NI-1:0] chunk,
  input  logic [LW-1:0]               valid_lanes,
  output logic [ELEMENT_WIDTH*NI-1:0] padded,
  output logic [NI-1:0]               mask
);

  // Per-lane pass-through or zero, mask bit j tracks lane j
  always_comb begin
    padded = '0;
    mask   = '0;
    for (int j = 0; j < NI; j++) begin
      if (LW'(j) < valid_lanes) begin
        padded[ELEMENT_WIDTH*(NI-j)-1 -: ELEMENT_WIDTH] = chunk[ELEMENT_WIDTH*(NI-j)-1 -: ELEMENT_WIDTH];
        mask[j] = 1'b1;
      end else begin
        padded[ELEMENT_WIDTH*(NI-j)-1 -: ELEMENT_WIDTH] = {ELEMENT_WIDTH{1'b0}};
        mask[j] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/complex_vxc_chunk_sequencer.sv
// Streams an NOE-element complex vector through an NI-lane vXc-add datapath one
// chunk at a time, zero-padding the tail and returning results with a lane mask.
module complex_vxc_chunk_sequencer
  import complex_vxc_chunk_sequencer_pkg::*;
#(
  parameter int NOE     = 19,
  parameter int NI      = 8,
  parameter int LATENCY = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        op_in,
  input  logic [ELEMENT_WIDTH-1:0]    constant_in,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ELEMENT_WIDTH*NI-1:0] in_x,
  input  logic [ELEMENT_WIDTH*NI-1:0] in_y,
  output logic [ELEMENT_WIDTH*NI-1:0] dp_first_row,
  output logic [ELEMENT_WIDTH*NI-1:0] dp_second_row,
  output logic [ELEMENT_WIDTH-1:0]    dp_constant,
  output logic                        dp_op,
  input  logic [ELEMENT_WIDTH*NI-1:0] dp_result,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ELEMENT_WIDTH*NI-1:0] out_data,
  output logic [NI-1:0]               out_mask,
  output logic                        busy,
  output logic                        done
);

  localparam int CW     = ELEMENT_WIDTH * NI;
  localparam int CHUNKS = chunks_f(NOE, NI);
  localparam int LW     = $clog2(NI + 1);
  localparam int CIDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int LCNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [LW-1:0]     FULL_LANES = LW'(NI);
  localparam logic [LW-1:0]     LAST_LANES = LW'(last_lanes_f(NOE, NI));
  localparam logic [CIDX_W-1:0] LAST_IDX   = CIDX_W'(CHUNKS - 1);
  localparam logic [LCNT_W-1:0] LAT_LAST   = LCNT_W'(LATENCY - 1);

  seq_state_e                 state_r;
  logic [CIDX_W-1:0]          chunk_idx_r;
  logic [LCNT_W-1:0]          lat_cnt_r;
  logic                       op_r;
  logic [ELEMENT_WIDTH-1:0]   const_r;
  logic [CW-1:0]              first_r;
  logic [CW-1:0]              second_r;
  logic [CW-1:0]              out_data_r;
  logic [NI-1:0]              out_mask_r;
  logic                       out_valid_r;
  logic                       in_ready_r;
  logic                       busy_r;
  logic                       done_r;

  logic                       is_last_s;
  logic [LW-1:0]              lanes_s;
  logic [CW-1:0]              x_pad_s;
  logic [CW-1:0]              y_pad_s;
  logic [CW-1:0]              res_pad_s;
  logic [NI-1:0]              x_mask_s;
  logic [NI-1:0]              y_mask_s;
  logic [NI-1:0]              res_mask_s;
  logic                       unused_mask_s;

  assign is_last_s = (chunk_idx_r == LAST_IDX);

  // Lane count of the chunk currently in flight; chunk_idx is stable from LOAD to HOLD
  always_comb begin
    if (is_last_s) begin
      lanes_s = LAST_LANES;
    end else begin
      lanes_s = FULL_LANES;
    end
  end

  complex_chunk_pad_mask #(.NI(NI), .LW(LW)) u_pad_x (
    .chunk       (in_x),
    .valid_lanes (lanes_s),
    .padded      (x_pad_s),
    .mask        (x_mask_s)
  );

  complex_chunk_pad_mask #(.NI(NI), .LW(LW)) u_pad_y (
    .chunk       (in_y),
    .valid_lanes (lanes_s),
    .padded      (y_pad_s),
    .mask        (y_mask_s)
  );

  complex_chunk_pad_mask #(.NI(NI), .LW(LW)) u_pad_res (
    .chunk       (dp_result),
    .valid_lanes (lanes_s),
    .padded      (res_pad_s),
    .mask        (res_mask_s)
  );

  // Input-side masks duplicate the output-side one
  assign unused_mask_s = ^{x_mask_s, y_mask_s};

  // Sequencer FSM with chunk and latency counters; all outputs registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      chunk_idx_r <= '0;
      lat_cnt_r   <= '0;
      op_r        <= 1'b0;
      const_r     <= '0;
      first_r     <= '0;
      second_r    <= '0;
      out_data_r  <= '0;
      out_mask_r  <= '0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            op_r        <= op_in;
            const_r     <= constant_in;
            chunk_idx_r <= '0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b1;
            state_r     <= ST_LOAD;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (in_valid && in_ready_r) begin
            first_r    <= x_pad_s;
            second_r   <= y_pad_s;
            lat_cnt_r  <= '0;
            in_ready_r <= 1'b0;
            state_r    <= ST_WAIT;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        ST_WAIT: begin
          // lat_cnt reaches LATENCY-1 on the (LATENCY-1)-th edge after the load
          if (lat_cnt_r == LAT_LAST) begin
            out_data_r  <= res_pad_s;
            out_mask_r  <= res_mask_s;
            out_valid_r <= 1'b1;
            state_r     <= ST_HOLD;
          end else begin
            lat_cnt_r <= lat_cnt_r + LCNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            if (is_last_s) begin
              out_mask_r <= '0;
              done_r     <= 1'b1;
              state_r    <= ST_DONE;
            end else begin
              chunk_idx_r <= chunk_idx_r + CIDX_W'(1);
              in_ready_r  <= 1'b1;
              state_r     <= ST_LOAD;
            end
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          done_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready      = in_ready_r;
  assign dp_first_row  = first_r;
  assign dp_second_row = second_r;
  assign dp_constant   = const_r;
  assign dp_op         = op_r;
  assign out_valid     = out_valid_r;
  assign out_data      = out_data_r;
  assign out_mask      = out_mask_r;
  assign busy          = busy_r;
  assign done          = done_r;

endmodule
